// File: rtl/ooo_pkg.sv
// Shared types for the instruction buffer: the 38-bit buffered entry and the
// fetch/dispatch widths.
package ooo_pkg;

  localparam int FETCH_W = 4;
  localparam int DISP_W  = 2;
  localparam int ENTRY_W = 38;

  // Field order fixes the packed layout on disp_entry_flat (opcode is the MSBs).
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] imm;
    logic [3:0] rt;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] a_owner;
    logic       a_dep;
    logic [3:0] b_owner;
    logic       b_dep;
    logic       uses_rb;
    logic       is_ld_str;
    logic       is_fxu;
    logic       is_branch;
  } ibuf_entry_t;

endpackage

// File: rtl/instr_buffer_if.sv
// Fetch-side bundle and dispatch-side signals of the instruction buffer.
// master = fetch/dispatch environment, slave = the buffer itself.
interface ibuf_if #(parameter int DEPTH = 8);
  import ooo_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                   if_valid_in;
  logic [15:0]            opcode_in_flat;
  logic [31:0]            immediate_in_flat;
  logic [15:0]            rt_in_flat;
  logic [15:0]            ra_in_flat;
  logic [15:0]            rb_in_flat;
  logic [15:0]            op_a_owner_in_flat;
  logic [15:0]            op_b_owner_in_flat;
  logic [3:0]             op_a_local_dep_in_flat;
  logic [3:0]             op_b_local_dep_in_flat;
  logic [3:0]             uses_rb_in_flat;
  logic [3:0]             is_ld_str_in_flat;
  logic [3:0]             is_fxu_in_flat;
  logic [3:0]             is_branch_in_flat;
  logic [2:0]             num_fetch;
  logic                   flush;
  logic [1:0]             disp_take;
  logic [DISP_W-1:0]      disp_valid;
  logic [2*ENTRY_W-1:0]   disp_entry_flat;
  logic [CW-1:0]          count;

  modport master (
    output if_valid_in, opcode_in_flat, immediate_in_flat, rt_in_flat, ra_in_flat,
           rb_in_flat, op_a_owner_in_flat, op_b_owner_in_flat, op_a_local_dep_in_flat,
           op_b_local_dep_in_flat, uses_rb_in_flat, is_ld_str_in_flat, is_fxu_in_flat,
           is_branch_in_flat, flush, disp_take,
    input  num_fetch, disp_valid, disp_entry_flat, count
  );

  modport slave (
    input  if_valid_in, opcode_in_flat, immediate_in_flat, rt_in_flat, ra_in_flat,
           rb_in_flat, op_a_owner_in_flat, op_b_owner_in_flat, op_a_local_dep_in_flat,
           op_b_local_dep_in_flat, uses_rb_in_flat, is_ld_str_in_flat, is_fxu_in_flat,
           is_branch_in_flat, flush, disp_take,
    output num_fetch, disp_valid, disp_entry_flat, count
  );

endinterface

// File: rtl/instr_buffer_mem.sv
// Entry storage for the instruction buffer: DEPTH x 38 bits, four write ports
// and two combinational read ports. Contents are deliberately not reset.
module ibuf_mem
  import ooo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic [FETCH_W-1:0]         wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr [FETCH_W],
  input  ibuf_entry_t                wr_data [FETCH_W],
  input  logic [$clog2(DEPTH)-1:0]   rd_addr [DISP_W],
  output ibuf_entry_t                rd_data [DISP_W]
);

  ibuf_entry_t mem [DEPTH];

  // Write addresses within one cycle are always distinct consecutive slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
    end
  end

  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      rd_data[k] = mem[rd_addr[k]];
    end
  end

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer between 4-wide fetch and 2-wide dispatch.
// Optional IBUF_PERF_EN adds saturating full-cycle and dispatched-entry counters.
module instr_buffer
  import ooo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  ibuf_if.slave       bus
`ifdef IBUF_PERF_EN
  ,
  output logic [15:0] perf_full_cycles,
  output logic [15:0] perf_dispatched
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]      head_q;
  logic [PW-1:0]      tail_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      free_cnt;
  logic [2:0]         num_fetch;
  logic [2:0]         wr_n;
  logic [1:0]         deq_n;
  logic [DISP_W-1:0]  disp_valid;

  ibuf_entry_t        lane_entry [FETCH_W];
  logic [FETCH_W-1:0] wr_en;
  logic [PW-1:0]      wr_addr    [FETCH_W];
  logic [PW-1:0]      rd_addr    [DISP_W];
  ibuf_entry_t        rd_entry   [DISP_W];
  ibuf_entry_t        slot0;
  ibuf_entry_t        slot1;

  // Acceptance depends only on registered occupancy, so a same-cycle dequeue
  // never opens room for fetch.
  always_comb begin
    free_cnt  = DEPTH_C - count_q;
    num_fetch = (free_cnt >= CW'(FETCH_W)) ? 3'(FETCH_W) : free_cnt[2:0];
    wr_n      = (bus.if_valid_in && !bus.flush) ? num_fetch : 3'd0;
  end

  always_comb begin
    deq_n = 2'd0;
    if (!bus.flush) begin
      deq_n = (CW'(bus.disp_take) > count_q) ? count_q[1:0] : bus.disp_take;
    end
  end

  // Lane n of each flat bus sits at bits [w*(3-n) +: w]; lane 0 is the oldest.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      lane_entry[i].opcode    = bus.opcode_in_flat[4*(3-i) +: 4];
      lane_entry[i].imm       = bus.immediate_in_flat[8*(3-i) +: 8];
      lane_entry[i].rt        = bus.rt_in_flat[4*(3-i) +: 4];
      lane_entry[i].ra        = bus.ra_in_flat[4*(3-i) +: 4];
      lane_entry[i].rb        = bus.rb_in_flat[4*(3-i) +: 4];
      lane_entry[i].a_owner   = bus.op_a_owner_in_flat[4*(3-i) +: 4];
      lane_entry[i].a_dep     = bus.op_a_local_dep_in_flat[3-i];
      lane_entry[i].b_owner   = bus.op_b_owner_in_flat[4*(3-i) +: 4];
      lane_entry[i].b_dep     = bus.op_b_local_dep_in_flat[3-i];
      lane_entry[i].uses_rb   = bus.uses_rb_in_flat[3-i];
      lane_entry[i].is_ld_str = bus.is_ld_str_in_flat[3-i];
      lane_entry[i].is_fxu    = bus.is_fxu_in_flat[3-i];
      lane_entry[i].is_branch = bus.is_branch_in_flat[3-i];
      wr_en[i]                = (3'(i) < wr_n);
      wr_addr[i]              = tail_q + PW'(i);
    end
  end

  ibuf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (lane_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  // Slots are masked when empty so stale storage never reaches the outputs.
  always_comb begin
    rd_addr[0]    = head_q;
    rd_addr[1]    = head_q + PW'(1);
    disp_valid[0] = (count_q != '0);
    disp_valid[1] = (count_q >= CW'(2));
    slot0         = disp_valid[0] ? rd_entry[0] : '0;
    slot1         = disp_valid[1] ? rd_entry[1] : '0;
  end

  assign bus.num_fetch       = num_fetch;
  assign bus.disp_valid      = disp_valid;
  assign bus.disp_entry_flat = {slot0, slot1};
  assign bus.count           = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(deq_n);
      tail_q  <= tail_q + PW'(wr_n);
      count_q <= count_q + CW'(wr_n) - CW'(deq_n);
    end
  end

`ifdef IBUF_PERF_EN
  logic [15:0] full_q;
  logic [15:0] disp_q;
  logic [16:0] disp_sum;

  assign disp_sum = {1'b0, disp_q} + 17'(deq_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      disp_q <= '0;
    end else begin
      if (count_q == DEPTH_C && full_q != 16'hFFFF) full_q <= full_q + 16'd1;
      disp_q <= disp_sum[16] ? 16'hFFFF : disp_sum[15:0];
    end
  end

  assign perf_full_cycles = full_q;
  assign perf_dispatched  = disp_q;
`else
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: a scoreboard queue holds the entries the
// buffer should have accepted, and dispatch slots are compared against its head.
module tb_instr_buffer;
  import ooo_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ibuf_if #(.DEPTH(DEPTH)) bus ();

`ifdef IBUF_PERF_EN
  logic [15:0] perf_full_cycles;
  logic [15:0] perf_dispatched;
`endif

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IBUF_PERF_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_dispatched  (perf_dispatched)
`endif
  );

  int checks = 0;
  int errors = 0;

  ibuf_entry_t sb[$];
  ibuf_entry_t lane [4];
  int m_cnt  = 0;
  int m_full = 0;
  int m_disp = 0;

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    ibuf_entry_t s0;
    ibuf_entry_t s1;
    logic [1:0]  exp_valid;
    s0 = bus.disp_entry_flat[75:38];
    s1 = bus.disp_entry_flat[37:0];
    exp_valid = {m_cnt >= 2, m_cnt >= 1};
    chk({tag, "_count"}, 64'(bus.count), 64'(m_cnt));
    chk({tag, "_num_fetch"}, 64'(bus.num_fetch), 64'(min_i(4, DEPTH - m_cnt)));
    chk({tag, "_disp_valid"}, 64'(bus.disp_valid), 64'(exp_valid));
    if (m_cnt >= 1) chk({tag, "_slot0"}, 64'(s0), 64'(sb[0]));
    if (m_cnt >= 2) chk({tag, "_slot1"}, 64'(s1), 64'(sb[1]));
`ifdef IBUF_PERF_EN
    chk({tag, "_perf_full"}, 64'(perf_full_cycles), 64'(m_full));
    chk({tag, "_perf_disp"}, 64'(perf_dispatched), 64'(m_disp));
`endif
  endtask

  // Drive one cycle of stimulus, check the pre-edge outputs, advance the model.
  task automatic cycle(string tag, bit v, bit fl, logic [1:0] take, int op_base);
    logic [15:0] opf, rtf, raf, rbf, aof, bof;
    logic [31:0] immf;
    logic [3:0]  adf, bdf, urf, lsf, fxf, brf;
    int acc;
    int deq;
    for (int n = 0; n < 4; n++) begin
      lane[n].opcode    = 4'(op_base + n);
      lane[n].imm       = 8'($urandom);
      lane[n].rt        = 4'($urandom);
      lane[n].ra        = 4'($urandom);
      lane[n].rb        = 4'($urandom);
      lane[n].a_owner   = 4'($urandom);
      lane[n].a_dep     = 1'($urandom);
      lane[n].b_owner   = 4'($urandom);
      lane[n].b_dep     = 1'($urandom);
      lane[n].uses_rb   = 1'($urandom);
      lane[n].is_ld_str = 1'($urandom);
      lane[n].is_fxu    = 1'($urandom);
      lane[n].is_branch = 1'($urandom);
      opf[4*(3-n) +: 4]  = lane[n].opcode;
      immf[8*(3-n) +: 8] = lane[n].imm;
      rtf[4*(3-n) +: 4]  = lane[n].rt;
      raf[4*(3-n) +: 4]  = lane[n].ra;
      rbf[4*(3-n) +: 4]  = lane[n].rb;
      aof[4*(3-n) +: 4]  = lane[n].a_owner;
      bof[4*(3-n) +: 4]  = lane[n].b_owner;
      adf[3-n] = lane[n].a_dep;
      bdf[3-n] = lane[n].b_dep;
      urf[3-n] = lane[n].uses_rb;
      lsf[3-n] = lane[n].is_ld_str;
      fxf[3-n] = lane[n].is_fxu;
      brf[3-n] = lane[n].is_branch;
    end
    bus.if_valid_in            = v;
    bus.flush                  = fl;
    bus.disp_take              = take;
    bus.opcode_in_flat         = opf;
    bus.immediate_in_flat      = immf;
    bus.rt_in_flat             = rtf;
    bus.ra_in_flat             = raf;
    bus.rb_in_flat             = rbf;
    bus.op_a_owner_in_flat     = aof;
    bus.op_b_owner_in_flat     = bof;
    bus.op_a_local_dep_in_flat = adf;
    bus.op_b_local_dep_in_flat = bdf;
    bus.uses_rb_in_flat        = urf;
    bus.is_ld_str_in_flat      = lsf;
    bus.is_fxu_in_flat         = fxf;
    bus.is_branch_in_flat      = brf;
    #1;
    check_outputs(tag);
    if (m_cnt == DEPTH) m_full = min_i(m_full + 1, 65535);
    acc = (v && !fl) ? min_i(4, DEPTH - m_cnt) : 0;
    deq = fl ? 0 : min_i(int'(take), m_cnt);
    m_disp = min_i(m_disp + deq, 65535);
    if (fl) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      repeat (deq) void'(sb.pop_front());
      for (int n = 0; n < acc; n++) sb.push_back(lane[n]);
      m_cnt = m_cnt + acc - deq;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.if_valid_in = 1'b0;
    bus.flush       = 1'b0;
    bus.disp_take   = 2'd0;
    bus.opcode_in_flat = '0;         bus.immediate_in_flat = '0;
    bus.rt_in_flat = '0;             bus.ra_in_flat = '0;
    bus.rb_in_flat = '0;             bus.op_a_owner_in_flat = '0;
    bus.op_b_owner_in_flat = '0;     bus.op_a_local_dep_in_flat = '0;
    bus.op_b_local_dep_in_flat = '0; bus.uses_rb_in_flat = '0;
    bus.is_ld_str_in_flat = '0;      bus.is_fxu_in_flat = '0;
    bus.is_branch_in_flat = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First bundle: opcodes 1..4, nothing taken.
    cycle("reset", 1'b1, 1'b0, 2'd0, 1);
    #1;
    chk("first_slot0_opcode", 64'(bus.disp_entry_flat[75:72]), 64'd1);
    chk("first_slot1_opcode", 64'(bus.disp_entry_flat[37:34]), 64'd2);
    cycle("first", 1'b1, 1'b0, 2'd2, 5);      // 4 -> 6
    cycle("partial", 1'b1, 1'b0, 2'd0, 9);    // 6 -> 8, only two lanes stored
    cycle("full_deq", 1'b1, 1'b0, 2'd2, 13);  // full: no write, 8 -> 6
    cycle("after_full", 1'b0, 1'b0, 2'd2, 0); // 6 -> 4
    cycle("drain1", 1'b0, 1'b0, 2'd1, 0);     // 4 -> 3
    cycle("flush", 1'b1, 1'b1, 2'd2, 3);      // -> 0
    cycle("post_flush", 1'b0, 1'b0, 2'd2, 0);

    for (int i = 0; i < 12; i++) cycle("stream", 1'b1, 1'b0, 2'd2, 4 * i);
    repeat (4) cycle("stream_drain", 1'b0, 1'b0, 2'd2, 0);

    cycle("odd_w", 1'b1, 1'b0, 2'd0, 7);      // -> 4
    cycle("odd_t1", 1'b0, 1'b0, 2'd1, 0);     // -> 3
    cycle("odd_t2", 1'b0, 1'b0, 2'd2, 0);     // -> 1
    cycle("take_gt_cnt", 1'b0, 1'b0, 2'd2, 0);// -> 0
    cycle("empty_take", 1'b0, 1'b0, 2'd2, 0);

    cycle("pre_rst_w1", 1'b1, 1'b0, 2'd0, 11);  // -> 4
    cycle("pre_rst_w2", 1'b1, 1'b0, 2'd2, 15);  // -> 6
    cycle("pre_rst_t1", 1'b0, 1'b0, 2'd1, 0);   // -> 5
    bus.if_valid_in = 1'b0;
    bus.disp_take   = 2'd0;
    #1;
    check_outputs("pre_rst");
    #1;
    rst = 1'b1;
    sb.delete();
    m_cnt  = 0;
    m_full = 0;
    m_disp = 0;
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst_w", 1'b1, 1'b0, 2'd0, 2);
    cycle("post_rst_chk", 1'b0, 1'b0, 2'd1, 0);
    cycle("final", 1'b0, 1'b0, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
